// File: rtl/md_ctrl_if.sv
// Multiply/divide unit bus: operation issue, operands, HI/LO read port and status.
// The master drives op/operands/read select; the slave returns busy and HI/LO.
interface md_ctrl_if;
   logic [2:0]  md_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        rd_sel;
   logic        busy;
   logic [31:0] md_out;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output md_op, rs_val, rt_val, rd_sel,
      input  busy, md_out, hi, lo
   );

   modport slave (
      input  md_op, rs_val, rt_val, rd_sel,
      output busy, md_out, hi, lo
   );
endinterface

// File: rtl/md_ctrl.sv
// Multi-cycle multiply/divide controller owning the HI/LO registers.
// Results are formed from operands latched at start and land on the last RUN edge.
//
//   state | meaning
//   IDLE  | accepts mult/div starts and mthi/mtlo writes
//   RUN   | counting down to completion; new ops ignored, busy high
module md_ctrl (
   input logic        clk,
   input logic        reset,
   md_ctrl_if.slave   bus
);
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [2:0]  op_q;
   logic [31:0] a_q, b_q;
   logic [31:0] hi_q, lo_q, hi_nxt, lo_nxt;
   logic        latch;

   logic signed [63:0] sprod;
   logic [63:0]        uprod;
   logic               a_neg, b_neg;
   logic [31:0]        a_mag, b_mag, uq, ur, quo, rem;

   assign sprod = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
   assign uprod = {32'd0, a_q} * {32'd0, b_q};

   // Signed divide works on magnitudes; MIN_INT / -1 wraps back to MIN_INT naturally.
   assign a_neg = (op_q == OP_DIV) && a_q[31];
   assign b_neg = (op_q == OP_DIV) && b_q[31];
   assign a_mag = a_neg ? (32'd0 - a_q) : a_q;
   assign b_mag = b_neg ? (32'd0 - b_q) : b_q;
   assign uq    = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
   assign ur    = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
   assign quo   = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
   assign rem   = a_neg ? (32'd0 - ur) : ur;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      hi_nxt    = hi_q;
      lo_nxt    = lo_q;
      latch     = 1'b0;
      case (state)
         IDLE: begin
            case (bus.md_op)
               OP_MULT, OP_MULTU: begin
                  latch     = 1'b1;
                  cnt_nxt   = 4'd5;
                  state_nxt = RUN;
               end
               OP_DIV, OP_DIVU: begin
                  latch     = 1'b1;
                  cnt_nxt   = 4'd10;
                  state_nxt = RUN;
               end
               OP_MTHI: hi_nxt = bus.rs_val;
               OP_MTLO: lo_nxt = bus.rs_val;
               default: ;
            endcase
         end
         RUN: begin
            if (cnt <= 4'd1) begin
               cnt_nxt   = 4'd0;
               state_nxt = IDLE;
               case (op_q)
                  OP_MULT:  {hi_nxt, lo_nxt} = sprod;
                  OP_MULTU: {hi_nxt, lo_nxt} = uprod;
                  OP_DIV, OP_DIVU: begin
                     if (b_q != 32'd0) begin
                        hi_nxt = rem;
                        lo_nxt = quo;
                     end
                  end
                  default: ;
               endcase
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         hi_q  <= 32'd0;
         lo_q  <= 32'd0;
         op_q  <= 3'd0;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         hi_q  <= hi_nxt;
         lo_q  <= lo_nxt;
         if (latch) begin
            op_q <= bus.md_op;
            a_q  <= bus.rs_val;
            b_q  <= bus.rt_val;
         end
      end
   end

   assign bus.busy   = (state == RUN);
   assign bus.hi     = hi_q;
   assign bus.lo     = lo_q;
   assign bus.md_out = bus.rd_sel ? lo_q : hi_q;
endmodule

// File: tb/tb_md_ctrl.sv
// Directed and random checks of md_ctrl against a HI/LO reference model,
// with expected results queued at issue and compared at completion.
module tb_md_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   md_ctrl_if bus ();
   md_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] ph,
                                         input logic [31:0] pl);
      logic signed [63:0] sa, sb, sq, sr;
      logic [63:0]        ua, ub;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         3'd1: return sa * sb;
         3'd2: return ua * ub;
         3'd3: begin
            if (b == 32'd0) return {ph, pl};
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
         end
         3'd4: begin
            if (b == 32'd0) return {ph, pl};
            return {(a % b), (a / b)};
         end
         3'd5: return {a, pl};
         3'd6: return {ph, a};
         default: return {ph, pl};
      endcase
   endfunction

   function automatic int op_cycles(input logic [2:0] op);
      if (op == 3'd1 || op == 3'd2) return 5;
      if (op == 3'd3 || op == 3'd4) return 10;
      return 0;
   endfunction

   task automatic push_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r;
      exp_t        e;
      r      = model(op, a, b, m_hi, m_lo);
      m_hi   = r[63:32];
      m_lo   = r[31:0];
      e.hi     = m_hi;
      e.lo     = m_lo;
      e.cycles = op_cycles(op);
      sb_q.push_back(e);
   endtask

   task automatic wait_and_score(input string tag, input int n_start);
      int   n;
      exp_t e;
      n = n_start;
      while (bus.busy === 1'b1 && n < 20) begin
         n++;
         step();
      end
      e = sb_q.pop_front();
      check({tag, "_busy_cycles"}, n, e.cycles);
      check({tag, "_hi"}, bus.hi, e.hi);
      check({tag, "_lo"}, bus.lo, e.lo);
   endtask

   task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      push_exp(op, a, b);
      bus.md_op  = op;
      bus.rs_val = a;
      bus.rt_val = b;
      step();
      bus.md_op  = 3'd0;
      bus.rs_val = $urandom;
      bus.rt_val = $urandom;
      wait_and_score(tag, 0);
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;

      reset      = 1'b1;
      bus.md_op  = 3'd0;
      bus.rs_val = 32'd0;
      bus.rt_val = 32'd0;
      bus.rd_sel = 1'b0;
      step();
      step();
      reset = 1'b0;
      check("reset_busy", {31'd0, bus.busy}, 32'd0);
      check("reset_hi", bus.hi, 32'd0);
      check("reset_lo", bus.lo, 32'd0);
      check("reset_md_out", bus.md_out, 32'd0);

      issue("mult", 3'd1, 32'hFFFFFFFE, 32'h00000003);
      check("mult_hi_const", bus.hi, 32'hFFFFFFFF);
      check("mult_lo_const", bus.lo, 32'hFFFFFFFA);

      issue("multu", 3'd2, 32'hFFFFFFFE, 32'h00000003);
      check("multu_hi_const", bus.hi, 32'h00000002);
      check("multu_lo_const", bus.lo, 32'hFFFFFFFA);

      issue("div", 3'd3, 32'hFFFFFFF9, 32'h00000002);
      check("div_lo_const", bus.lo, 32'hFFFFFFFD);
      check("div_hi_const", bus.hi, 32'hFFFFFFFF);

      issue("divu", 3'd4, 32'h00000007, 32'h00000002);
      check("divu_lo_const", bus.lo, 32'h00000003);
      check("divu_hi_const", bus.hi, 32'h00000001);

      issue("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF);
      check("div_ovf_lo_const", bus.lo, 32'h80000000);
      check("div_ovf_hi_const", bus.hi, 32'h00000000);

      // md_out reflects registered HI until the write edge passes
      bus.md_op  = 3'd5;
      bus.rs_val = 32'h12345678;
      bus.rd_sel = 1'b0;
      #1;
      check("mthi_read_old", bus.md_out, 32'h00000000);
      issue("mthi", 3'd5, 32'h12345678, 32'h0);
      issue("divu_by0", 3'd4, 32'h00000055, 32'h00000000);
      check("divu_by0_hi_const", bus.hi, 32'h12345678);
      bus.rd_sel = 1'b0;
      #1;
      check("divu_by0_md_out_hi", bus.md_out, 32'h12345678);
      bus.rd_sel = 1'b1;
      #1;
      check("divu_by0_md_out_lo", bus.md_out, 32'h80000000);

      issue("mult_b2b", 3'd1, 32'h00010000, 32'h00030000);
      issue("mtlo_b2b", 3'd6, 32'hA5A5A5A5, 32'h0);
      check("b2b_lo_const", bus.lo, 32'hA5A5A5A5);
      check("b2b_hi_const", bus.hi, 32'h00000003);
      check("b2b_busy", {31'd0, bus.busy}, 32'd0);

      // mult issued mid-divide must not restart or alter the result
      push_exp(3'd3, 32'd100, 32'd7);
      bus.md_op  = 3'd3;
      bus.rs_val = 32'd100;
      bus.rt_val = 32'd7;
      step();
      bus.md_op = 3'd0;
      step();
      step();
      bus.md_op  = 3'd1;
      bus.rs_val = 32'd5;
      bus.rt_val = 32'd5;
      step();
      bus.md_op = 3'd0;
      wait_and_score("div_ignore_mult", 3);
      check("div_ignore_lo_const", bus.lo, 32'd14);

      // reset mid-run with a stray mult at busy cycle 3
      bus.md_op  = 3'd3;
      bus.rs_val = 32'd1000;
      bus.rt_val = 32'd3;
      step();
      bus.md_op = 3'd0;
      step();
      step();
      bus.md_op = 3'd1;
      step();
      bus.md_op = 3'd0;
      step();
      step();
      check("rst_run_busy_before", {31'd0, bus.busy}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      m_hi  = 32'd0;
      m_lo  = 32'd0;
      check("rst_run_busy_after", {31'd0, bus.busy}, 32'd0);
      check("rst_run_hi", bus.hi, 32'd0);
      check("rst_run_lo", bus.lo, 32'd0);
      step();
      check("rst_run_busy_next", {31'd0, bus.busy}, 32'd0);

      issue("pre_prio_mtlo", 3'd6, 32'h0BADF00D, 32'h0);
      bus.md_op  = 3'd5;
      bus.rs_val = 32'hDEADBEEF;
      reset      = 1'b1;
      step();
      reset     = 1'b0;
      bus.md_op = 3'd0;
      m_hi      = 32'd0;
      m_lo      = 32'd0;
      check("rst_prio_hi", bus.hi, 32'd0);
      check("rst_prio_lo", bus.lo, 32'd0);
      check("rst_prio_busy", {31'd0, bus.busy}, 32'd0);

      for (int i = 0; i < 12; i++) begin
         rop = 3'($urandom_range(1, 6));
         ra  = $urandom;
         rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if (i == 3) rb = 32'd0;
         issue($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
